ready_barrier_fsm: RTL and testbench
====================================

READY_BARRIER_FSM -- requirements
Module: ready_barrier_fsm

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of players (legal range 2..8).
REQ-002 SHALL have parameter COORD_W, default 4, width of each per-player x and y coordinate.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, maximum COLLECT dwell in cycles (>=1).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ready_in  input  N_PLAYERS  per-player ready request, bit i = player i.
REQ-008 x_in, y_in  input  N_PLAYERS*COORD_W each  packed coordinates; player i occupies bits [i*COORD_W +: COORD_W].
REQ-009 out_ready  input  1  consumer accepts released coordinates.
REQ-010 out_valid  output  1  released coordinate set is valid.
REQ-011 x_out, y_out  output  N_PLAYERS*COORD_W each  latched coordinates, same packing as inputs.
REQ-012 ready_mask  output  N_PLAYERS  registered set of players already latched this round.
REQ-013 timeout_pulse  output  1  one-cycle round-abort indication.

Function
REQ-014 SHALL implement states IDLE, COLLECT, RELEASE, ABORT.
REQ-015 IDLE: on any ready_in bit high, SHALL latch x/y of each requesting player, set its mask bit, go to RELEASE if mask becomes all-ones, else COLLECT.
REQ-016 COLLECT: each ready_in bit high with mask bit 0 SHALL latch that player's x/y and set the mask bit in the same edge.
REQ-017 Already-latched players SHALL ignore further ready_in and coordinate changes until the round ends.
REQ-018 COLLECT SHALL go to RELEASE on the edge at which mask becomes all-ones.
REQ-019 Latency: out_valid SHALL rise the cycle after the edge that samples the last missing ready_in.
REQ-020 RELEASE: out_valid=1, x_out/y_out = latched values, held stable until out_ready is sampled high.
REQ-021 RELEASE with out_ready high SHALL clear mask and latches and go to IDLE; ready_in sampled in RELEASE SHALL be ignored.
REQ-022 When not in RELEASE, out_valid SHALL be 0 and x_out/y_out SHALL be all zeros.
REQ-023 Timeout counter SHALL count COLLECT cycles from 0; when it reaches TIMEOUT_CYCLES-1 and the round does not complete that edge, go to ABORT.
REQ-024 Completion and timeout on the same edge: completion SHALL win (RELEASE, no timeout_pulse).
REQ-025 ABORT: timeout_pulse=1 for exactly one cycle, mask and latches cleared, next state IDLE.
REQ-026 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); it SHALL clear on leaving COLLECT.

Reset
REQ-027 reset SHALL force IDLE, counter 0, mask 0, latches 0, out_valid 0, x_out/y_out 0, timeout_pulse 0, including mid-COLLECT or mid-RELEASE.

Configuration
REQ-028 Macro READY_BARRIER_TIMEOUT_EN defined: REQ-023..REQ-026 active.
REQ-029 Macro READY_BARRIER_TIMEOUT_EN undefined: no counter, ABORT unreachable, COLLECT waits indefinitely, timeout_pulse tied 0.

Structure
REQ-030 Package ready_barrier_pkg SHALL hold the state enum typedef and default parameter constants.
REQ-031 Sub-module barrier_timeout_ctr (clear, enable, expire output) SHALL implement the counter, instantiated only under READY_BARRIER_TIMEOUT_EN.

Verification (N_PLAYERS=2, COORD_W=4, TIMEOUT_CYCLES=8, macro defined unless noted)
REQ-032 Reset asserted -> all outputs 0, ready_mask 2'b00.
REQ-033 P0 ready x=3,y=5; P0 coords change to 7,7; P1 ready 3 cycles later x=9,y=2 -> next cycle out_valid=1, x_out=8'h93, y_out=8'h25.
REQ-034 Both ready same cycle, out_ready low 4 cycles -> out_valid and data stable 4 cycles, IDLE one cycle after out_ready sampled.
REQ-035 Only P0 ready -> timeout_pulse high one cycle after 8 COLLECT cycles, ready_mask 0, state IDLE; macro undefined -> no pulse after 50 cycles.
REQ-036 P1 ready on the 8th COLLECT cycle -> RELEASE, timeout_pulse stays 0.
REQ-037 reset pulsed during COLLECT with mask 2'b01 -> mask 0, IDLE, outputs 0 asynchronously.

Source files
------------

// File: rtl/ready_barrier_pkg.sv
// ready_barrier_pkg -- shared types and default configuration for the ready barrier.
//
// Contents:
//   state_t             barrier FSM state encoding (IDLE, COLLECT, RELEASE, ABORT)
//   DEF_N_PLAYERS       default number of players
//   DEF_COORD_W         default width of each x / y coordinate
//   DEF_TIMEOUT_CYCLES  default maximum COLLECT dwell in cycles
package ready_barrier_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RELEASE = 2'd2,
        ABORT   = 2'd3
    } state_t;

    localparam int unsigned DEF_N_PLAYERS      = 2;
    localparam int unsigned DEF_COORD_W        = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/barrier_timeout_ctr.sv
// barrier_timeout_ctr -- dwell counter for the COLLECT phase of the ready barrier.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   clear   in   synchronous clear, wins over enable
//   enable  in   count one cycle (high while the barrier is collecting)
//   expire  out  high during the enabled cycle whose count equals LIMIT-1
import ready_barrier_pkg::*;

module barrier_timeout_ctr #(
    parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned     CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of process ordering in simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/ready_barrier_fsm.sv
// ready_barrier_fsm -- waits for every player to raise ready, latching each
// player's coordinates at the moment it does, then releases the full set.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   ready_in       in   [N_PLAYERS]          per-player ready request
//   x_in, y_in     in   [N_PLAYERS*COORD_W]  packed coordinates, player i at [i*COORD_W +: COORD_W]
//   out_ready      in   consumer accepts the released set
//   out_valid      out  released set is valid (RELEASE state)
//   x_out, y_out   out  [N_PLAYERS*COORD_W]  latched coordinates, zero outside RELEASE
//   ready_mask     out  [N_PLAYERS]          players already latched this round
//   timeout_pulse  out  one-cycle round-abort indication
//
// Build option: define READY_BARRIER_TIMEOUT_EN to abort a round that stays in
// COLLECT for TIMEOUT_CYCLES cycles. Without it COLLECT waits indefinitely and
// timeout_pulse is constant 0.
import ready_barrier_pkg::*;

module ready_barrier_fsm #(
    parameter int unsigned N_PLAYERS      = DEF_N_PLAYERS,
    parameter int unsigned COORD_W        = DEF_COORD_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_PLAYERS-1:0]           ready_in,
    input  logic [N_PLAYERS*COORD_W-1:0]   x_in,
    input  logic [N_PLAYERS*COORD_W-1:0]   y_in,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [N_PLAYERS*COORD_W-1:0]   x_out,
    output logic [N_PLAYERS*COORD_W-1:0]   y_out,
    output logic [N_PLAYERS-1:0]           ready_mask,
    output logic                           timeout_pulse
);

    localparam int unsigned DW = N_PLAYERS * COORD_W;

    state_t                 state, state_d;
    logic [N_PLAYERS-1:0]   mask, mask_d, take;
    logic [DW-1:0]          x_lat, y_lat, x_d, y_d;
    logic                   expire;

    // Next-state and latch update. A player is taken only while its mask bit is
    // clear, so later ready/coordinate changes of latched players are ignored.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state;
        mask_d  = mask;
        x_d     = x_lat;
        y_d     = y_lat;
        take    = '0;

        case (state)
            IDLE, COLLECT: begin
                take   = ready_in & ~mask;
                mask_d = mask | take;
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (take[i]) begin
                        x_d[i*COORD_W +: COORD_W] = x_in[i*COORD_W +: COORD_W];
                        y_d[i*COORD_W +: COORD_W] = y_in[i*COORD_W +: COORD_W];
                    end
                end
                // Completion is tested before expiry, so it wins a same-edge tie.
                if (&mask_d) begin
                    state_d = RELEASE;
                end else if (state == IDLE) begin
                    if (|ready_in) begin
                        state_d = COLLECT;
                    end
                end else if (expire) begin
                    state_d = ABORT;
                    mask_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            RELEASE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask  <= '0;
            x_lat <= '0;
            y_lat <= '0;
        end else begin
            mask  <= mask_d;
            x_lat <= x_d;
            y_lat <= y_d;
        end
    end

    assign out_valid  = (state == RELEASE);
    assign x_out      = out_valid ? x_lat : '0;
    assign y_out      = out_valid ? y_lat : '0;
    assign ready_mask = mask;

`ifdef READY_BARRIER_TIMEOUT_EN
    // Counts only while collecting and clears on any exit from COLLECT.
    barrier_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_d != COLLECT),
        .enable (state == COLLECT),
        .expire (expire)
    );

    assign timeout_pulse = (state == ABORT);
`else
    logic unused_timeout_cfg;

    assign expire        = 1'b0;
    assign timeout_pulse = 1'b0;
    // Keeps TIMEOUT_CYCLES referenced when the timeout is compiled out.
    assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 1);
`endif

endmodule

// File: tb/tb_ready_barrier_fsm.sv
// tb_ready_barrier_fsm -- directed, scoreboard-checked bench for ready_barrier_fsm
// (N_PLAYERS=2, COORD_W=4, TIMEOUT_CYCLES=8). Timeout expectations follow
// READY_BARRIER_TIMEOUT_EN.
`timescale 1ns/1ps

module tb_ready_barrier_fsm;

    localparam int unsigned NP = 2;
    localparam int unsigned CW = 4;
    localparam int unsigned TO = 8;

    typedef enum logic {EXP_RELEASE, EXP_ABORT} exp_kind_t;
    typedef struct {
        exp_kind_t        kind;
        logic [NP*CW-1:0] x;
        logic [NP*CW-1:0] y;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    ready_in;
    logic [NP*CW-1:0] x_in, y_in;
    logic             out_ready;
    logic             out_valid;
    logic [NP*CW-1:0] x_out, y_out;
    logic [NP-1:0]    ready_mask;
    logic             timeout_pulse;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    ready_barrier_fsm #(
        .N_PLAYERS      (NP),
        .COORD_W        (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ready_in      (ready_in),
        .x_in          (x_in),
        .y_in          (y_in),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .x_out         (x_out),
        .y_out         (y_out),
        .ready_mask    (ready_mask),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_release(input logic [NP*CW-1:0] x, input logic [NP*CW-1:0] y);
        exp_t e;
        e.kind = EXP_RELEASE;
        e.x    = x;
        e.y    = y;
        sb.push_back(e);
    endtask

    task automatic expect_abort();
        exp_t e;
        e.kind = EXP_ABORT;
        e.x    = '0;
        e.y    = '0;
        sb.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_x"},     32'(x_out),     32'd0);
        check({tag, "_y"},     32'(y_out),     32'd0);
        check({tag, "_mask"},  32'(ready_mask), 32'd0);
        check({tag, "_pulse"}, 32'(timeout_pulse), 32'd0);
    endtask

    // Monitor: every accepted release and every abort pulse consumes one expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_release: got x=%0h y=%0h, expected no release", x_out, y_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_kind_release", 32'(EXP_RELEASE), 32'(e.kind));
                    check("sb_x_out", 32'(x_out), 32'(e.x));
                    check("sb_y_out", 32'(y_out), 32'(e.y));
                end
            end
            if (timeout_pulse) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_timeout: got pulse, expected none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_kind_abort", 32'(EXP_ABORT), 32'(e.kind));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        ready_in  = '0;
        x_in      = '0;
        y_in      = '0;
        out_ready = 1'b0;

        // Reset state
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // Staggered arrival: P0 at (3,5), later coordinate change ignored, P1 at (9,2)
        out_ready = 1'b1;
        ready_in  = 2'b01;
        x_in      = 8'h03;
        y_in      = 8'h05;
        tick();
        check("stagger_mask_p0", 32'(ready_mask), 32'h1);
        check("stagger_valid_collect", 32'(out_valid), 32'd0);
        x_in = 8'h07;
        y_in = 8'h07;
        tick();
        ready_in = 2'b00;
        tick();
        ready_in = 2'b10;
        x_in     = 8'h97;
        y_in     = 8'h27;
        expect_release(8'h93, 8'h25);
        tick();
        ready_in = 2'b00;
        check("stagger_valid", 32'(out_valid), 32'd1);
        check("stagger_x_out", 32'(x_out), 32'h93);
        check("stagger_y_out", 32'(y_out), 32'h25);
        tick();
        check_idle_outputs("stagger_done");

        // Both ready together, consumer stalls for 4 cycles
        out_ready = 1'b0;
        ready_in  = 2'b11;
        x_in      = 8'hA4;
        y_in      = 8'h1F;
        tick();
        x_in = 8'h55;
        y_in = 8'h66;
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_x_out", 32'(x_out), 32'hA4);
            check("stall_y_out", 32'(y_out), 32'h1F);
            tick();
        end
        ready_in  = 2'b00;
        out_ready = 1'b1;
        expect_release(8'hA4, 8'h1F);
        tick();
        check_idle_outputs("stall_done");
        out_ready = 1'b0;

        // Only P0 ready: round times out after 8 COLLECT cycles
        ready_in = 2'b01;
        x_in     = 8'h0C;
        y_in     = 8'h0D;
        tick();
        ready_in = 2'b00;
        for (int i = 0; i < 7; i++) tick();
        check("to_no_early_pulse", 32'(timeout_pulse), 32'd0);
        check("to_mask_before", 32'(ready_mask), 32'h1);
`ifdef READY_BARRIER_TIMEOUT_EN
        expect_abort();
        tick();
        check("to_pulse", 32'(timeout_pulse), 32'd1);
        check("to_mask_cleared", 32'(ready_mask), 32'h0);
        check("to_valid", 32'(out_valid), 32'd0);
        tick();
        check_idle_outputs("to_after");
`else
        for (int i = 0; i < 43; i++) tick();
        check("to_disabled_pulse", 32'(timeout_pulse), 32'd0);
        check("to_disabled_mask", 32'(ready_mask), 32'h1);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        check_idle_outputs("to_disabled_reset");
`endif

        // Completion on the 8th COLLECT cycle wins over the timeout
        out_ready = 1'b1;
        ready_in  = 2'b01;
        x_in      = 8'h0E;
        y_in      = 8'h01;
        tick();
        ready_in = 2'b00;
        for (int i = 0; i < 7; i++) tick();
        ready_in = 2'b10;
        x_in     = 8'h6F;
        y_in     = 8'h8F;
        expect_release(8'h6E, 8'h81);
        tick();
        ready_in = 2'b00;
        check("tie_pulse", 32'(timeout_pulse), 32'd0);
        check("tie_valid", 32'(out_valid), 32'd1);
        check("tie_x_out", 32'(x_out), 32'h6E);
        tick();
        check_idle_outputs("tie_done");

        // Asynchronous reset mid-COLLECT
        out_ready = 1'b0;
        ready_in  = 2'b01;
        x_in      = 8'h0B;
        y_in      = 8'h0A;
        tick();
        ready_in = 2'b00;
        check("midcollect_mask", 32'(ready_mask), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("midcollect_reset");
        #2 reset = 1'b0;
        // From IDLE, both ready at once must go straight to RELEASE.
        ready_in  = 2'b11;
        x_in      = 8'h21;
        y_in      = 8'h43;
        out_ready = 1'b1;
        expect_release(8'h21, 8'h43);
        tick();
        ready_in = 2'b00;
        check("post_reset_release", 32'(out_valid), 32'd1);
        tick();
        check_idle_outputs("post_reset_done");

        // Asynchronous reset mid-RELEASE
        out_ready = 1'b0;
        ready_in  = 2'b11;
        x_in      = 8'hED;
        y_in      = 8'hCB;
        tick();
        ready_in = 2'b00;
        check("midrelease_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("midrelease_reset");
        #2 reset = 1'b0;
        tick();
        check_idle_outputs("midrelease_after");

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
